// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared constants and types for the stream_demux block.
//               DEFAULT_WIDTH - default payload width
//               N_OUT         - number of output lanes (fixed at 4)
//               lane_idx_t    - lane selector type
//               count_t       - per-lane delivered-word counter type
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int N_OUT         = 4;

  typedef logic [1:0] lane_idx_t;
  typedef logic [7:0] count_t;

endpackage
`default_nettype wire

// File: rtl/stream_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_if
// Description : Handshake bundle between an upstream producer, stream_demux
//               and its N_OUT downstream consumers.
//               up_valid/up_ready/up_data/up_sel - single upstream stream
//               down_valid/down_ready/down_data  - one stream per lane
//               lane_count                       - per-lane delivered count
//               modport slave  : the demux side
//               modport master : the producer/consumer (environment) side
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                         up_valid;
  logic                         up_ready;
  logic [WIDTH-1:0]             up_data;
  lane_idx_t                    up_sel;
  logic [N_OUT-1:0]             down_valid;
  logic [N_OUT-1:0]             down_ready;
  logic [N_OUT-1:0][WIDTH-1:0]  down_data;
  count_t [N_OUT-1:0]           lane_count;

  modport slave (
    input  up_valid, up_data, up_sel, down_ready,
    output up_ready, down_valid, down_data, lane_count
  );

  modport master (
    output up_valid, up_data, up_sel, down_ready,
    input  up_ready, down_valid, down_data, lane_count
  );

endinterface
`default_nettype wire

// File: rtl/stream_demux_lane_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo2
// Description : Two-entry in-order FIFO used for one demux lane.
//               clk, rst        - clock, asynchronous active-high reset
//               push, push_data - write request and payload
//               pop             - read request (consumes head)
//               valid           - at least one word stored
//               full            - two words stored
//               head            - oldest stored word (don't-care when empty)
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       occ;
  logic             do_push;
  logic             do_pop;

  // Guard locally as well so the FIFO can never over- or under-run.
  assign do_push = push && (occ != 2'd2);
  assign do_pop  = pop  && (occ != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign valid = (occ != 2'd0);
  assign full  = (occ == 2'd2);
  assign head  = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux
// Description : Routes one upstream valid/ready stream to one of N_OUT lanes
//               selected by up_sel; each lane buffers up to two words and
//               counts the words it delivers.
//               clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - stream_demux_if slave modport (all stream signals)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  stream_demux_if.slave bus
);

  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] push;
  logic [N_OUT-1:0] pop;
  count_t           cnt [N_OUT];

  // Readiness looks only at the selected lane's stored state, so a lane
  // that is full stays closed even if it is draining this same cycle.
  assign bus.up_ready = ~full[bus.up_sel];

  generate
    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
      assign push[i] = bus.up_valid && bus.up_ready && (bus.up_sel == lane_idx_t'(i));
      assign pop[i]  = bus.down_valid[i] && bus.down_ready[i];

      lane_fifo2 #(
        .WIDTH (WIDTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push[i]),
        .push_data (bus.up_data),
        .pop       (pop[i]),
        .valid     (bus.down_valid[i]),
        .full      (full[i]),
        .head      (bus.down_data[i])
      );

      assign bus.lane_count[i] = cnt[i];
    end
  endgenerate

  // Delivered-word counters; 8-bit arithmetic wraps 255 -> 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) cnt[j] <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (pop[j]) cnt[j] <= cnt[j] + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux
// Description : Self-checking bench for stream_demux: per-lane list model,
//               every-cycle comparison, directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8)) bus ();

  stream_demux #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each lane is an ordered list of at most two words.
  logic [7:0] mq   [4][2];
  int         occ  [4] = '{default: 0};
  int         mcnt [4] = '{default: 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        occ[i]  = 0;
        mcnt[i] = 0;
      end
    end else begin
      logic       acc;
      int         s;
      acc = bus.up_valid && (occ[bus.up_sel] < 2);
      s   = int'(bus.up_sel);
      for (int i = 0; i < 4; i++) begin
        if (occ[i] > 0 && bus.down_ready[i]) begin
          mq[i][0] = mq[i][1];
          occ[i]   = occ[i] - 1;
          mcnt[i]  = mcnt[i] + 1;
        end
      end
      if (acc) begin
        mq[s][occ[s]] = bus.up_data;
        occ[s]        = occ[s] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check($sformatf("m_valid%0d", i), 32'(bus.down_valid[i]), 32'(occ[i] != 0));
      if (occ[i] != 0)
        check($sformatf("m_data%0d", i), 32'(bus.down_data[i]), 32'(mq[i][0]));
      check($sformatf("m_count%0d", i), 32'(bus.lane_count[i]), 32'(mcnt[i] % 256));
    end
    check("m_up_ready", 32'(bus.up_ready), 32'(occ[bus.up_sel] < 2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(200000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.up_valid   = 1'b0;
    bus.up_data    = '0;
    bus.up_sel     = '0;
    bus.down_ready = '0;
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_valid", 32'(bus.down_valid), 32'h0);
    check("rst_count", 32'(bus.lane_count), 32'h0);
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      bus.up_sel = 2'(s);
      #1 check("post_rst_ready", 32'(bus.up_ready), 32'h1);
    end

    // Single word to lane 2 with every consumer ready.
    bus.down_ready = 4'hF;
    bus.up_valid = 1'b1; bus.up_sel = 2'd2; bus.up_data = 8'hA5;
    tick();
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("a5_valid", 32'(bus.down_valid), 32'b0100);
    check("a5_data", 32'(bus.down_data[2]), 32'hA5);
    tick();
    @(negedge clk);
    check("a5_gone", 32'(bus.down_valid), 32'h0);
    check("a5_count", 32'(bus.lane_count[2]), 32'd1);

    // Three words to a stalled lane 1, then drain.
    tick();
    bus.down_ready = 4'h0;
    bus.up_valid = 1'b1; bus.up_sel = 2'd1; bus.up_data = 8'h11;
    @(negedge clk); check("l1_ready0", 32'(bus.up_ready), 32'h1);
    tick(); bus.up_data = 8'h22;
    @(negedge clk); check("l1_ready1", 32'(bus.up_ready), 32'h1);
    tick(); bus.up_data = 8'h33;
    @(negedge clk); check("l1_full", 32'(bus.up_ready), 32'h0);
    tick();
    bus.down_ready = 4'b0010;
    @(negedge clk);
    check("l1_full_pop", 32'(bus.up_ready), 32'h0);
    check("l1_head11", 32'(bus.down_data[1]), 32'h11);
    tick();
    @(negedge clk);
    check("l1_reopen", 32'(bus.up_ready), 32'h1);
    check("l1_head22", 32'(bus.down_data[1]), 32'h22);
    tick();
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("l1_head33", 32'(bus.down_data[1]), 32'h33);
    check("l1_occ1", 32'(bus.down_valid[1]), 32'h1);
    tick();
    @(negedge clk);
    check("l1_empty", 32'(bus.down_valid[1]), 32'h0);
    check("l1_count", 32'(bus.lane_count[1]), 32'd3);

    // Full lane 0 popping in the same cycle still refuses the push.
    tick();
    bus.down_ready = 4'h0;
    bus.up_valid = 1'b1; bus.up_sel = 2'd0; bus.up_data = 8'h41;
    tick(); bus.up_data = 8'h42;
    tick(); bus.up_data = 8'h43; bus.down_ready = 4'b0001;
    @(negedge clk); check("l0_refuse", 32'(bus.up_ready), 32'h0);
    tick();
    @(negedge clk); check("l0_accept", 32'(bus.up_ready), 32'h1);
    tick();
    bus.up_valid = 1'b0;
    @(negedge clk); check("l0_head43", 32'(bus.down_data[0]), 32'h43);
    tick();
    @(negedge clk); check("l0_count", 32'(bus.lane_count[0]), 32'd3);

    // Round-robin at full throughput.
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    bus.down_ready = 4'hF;
    for (int k = 0; k < 64; k++) begin
      bus.up_valid = 1'b1; bus.up_sel = 2'(k % 4); bus.up_data = 8'($urandom);
      @(negedge clk); check("rr_ready", 32'(bus.up_ready), 32'h1);
      tick();
    end
    bus.up_valid = 1'b0;
    tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("rr_count", 32'(bus.lane_count[i]), 32'd16);
    check("rr_drained", 32'(bus.down_valid), 32'h0);

    // Random traffic against the model.
    tick();
    for (int k = 0; k < 300; k++) begin
      bus.up_valid   = 1'($urandom);
      bus.up_sel     = 2'($urandom);
      bus.up_data    = 8'($urandom);
      bus.down_ready = 4'($urandom);
      tick();
    end
    bus.up_valid = 1'b0; bus.down_ready = 4'hF;
    repeat (3) tick();

    // Lane 3 counter wrap.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.down_ready = 4'b1000;
    for (int k = 0; k < 256; k++) begin
      bus.up_valid = 1'b1; bus.up_sel = 2'd3; bus.up_data = 8'(k);
      tick();
    end
    bus.up_valid = 1'b0;
    @(negedge clk); check("wrap_255", 32'(bus.lane_count[3]), 32'd255);
    tick();
    @(negedge clk);
    check("wrap_0", 32'(bus.lane_count[3]), 32'd0);
    check("wrap_empty", 32'(bus.down_valid), 32'h0);

    // Mid-cycle reset discards buffered words.
    tick();
    bus.down_ready = 4'b0001;
    bus.up_valid = 1'b1; bus.up_sel = 2'd0; bus.up_data = 8'hAA;
    tick(); bus.up_data = 8'hBB;
    tick(); bus.down_ready = 4'h0; bus.up_data = 8'hCC;
    tick(); bus.up_sel = 2'd3; bus.up_data = 8'hDD;
    tick(); bus.up_data = 8'hEE;
    tick(); bus.up_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.down_valid), 32'b1001);
    check("pre_rst_count", 32'(bus.lane_count[0]), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(bus.down_valid), 32'h0);
    check("async_count", 32'(bus.lane_count), 32'h0);
    bus.down_ready = 4'hF;
    tick(); tick();
    rst = 1'b0;
    bus.up_valid = 1'b1; bus.up_sel = 2'd0; bus.up_data = 8'h5A;
    tick();
    bus.up_valid = 1'b0;
    @(negedge clk);
    check("new_valid", 32'(bus.down_valid), 32'b0001);
    check("new_data", 32'(bus.down_data[0]), 32'h5A);
    check("new_count0", 32'(bus.lane_count[0]), 32'd0);
    tick();
    @(negedge clk);
    check("new_count1", 32'(bus.lane_count[0]), 32'd1);
    check("new_drained", 32'(bus.down_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
